// File: rtl/far_path_seq.sv
// Far-path mantissa unit: swaps operands by exponent, aligns the small mantissa one bit
// per cycle with guard/round/sticky, adds or subtracts, then applies one-bit normalization.
module far_path_seq #(
  parameter int unsigned SIZE_MANTISSA = 24,
  parameter int unsigned SIZE_EXPONENT = 8,
  parameter int unsigned SIZE_COUNTER  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     eff_op,
  input  logic [SIZE_MANTISSA-1:0] m_a_number,
  input  logic [SIZE_MANTISSA-1:0] m_b_number,
  input  logic [SIZE_EXPONENT-1:0] e_a_number,
  input  logic [SIZE_EXPONENT-1:0] e_b_number,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE_MANTISSA-1:0] resulted_m_o,
  output logic [2:0]               grs_o,
  output logic [SIZE_EXPONENT-1:0] resulted_e_o,
  output logic                     swap_o
);

  localparam int unsigned ShW  = SIZE_MANTISSA + 2;
  localparam int unsigned SumW = SIZE_MANTISSA + 4;

  typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StDone} state_e;

  state_e                   state_q, state_d;
  logic [SIZE_MANTISSA-1:0] m_big_q, m_big_d;
  logic [SIZE_EXPONENT-1:0] e_big_q, e_big_d;
  logic [ShW-1:0]           small_q, small_d;
  logic                     sticky_q, sticky_d;
  logic                     op_q, op_d;
  logic                     swap_q, swap_d;
  logic [SIZE_COUNTER-1:0]  cnt_q, cnt_d;
  logic [SumW-1:0]          sum_q, sum_d;
  logic [SIZE_MANTISSA-1:0] res_m_q, res_m_d;
  logic [2:0]               grs_q, grs_d;
  logic [SIZE_EXPONENT-1:0] res_e_q, res_e_d;
  logic                     swap_out_q, swap_out_d;

  logic                     a_big;
  logic [SIZE_EXPONENT-1:0] diff;
  logic [SumW-1:0]          big_ext, small_ext;

  assign a_big     = (e_a_number >= e_b_number);
  assign diff      = a_big ? (e_a_number - e_b_number) : (e_b_number - e_a_number);
  assign big_ext   = {1'b0, m_big_q, 3'b000};
  assign small_ext = {1'b0, small_q, sticky_q};

  always_comb begin
    state_d    = state_q;
    m_big_d    = m_big_q;
    e_big_d    = e_big_q;
    small_d    = small_q;
    sticky_d   = sticky_q;
    op_d       = op_q;
    swap_d     = swap_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    res_m_d    = res_m_q;
    grs_d      = grs_q;
    res_e_d    = res_e_q;
    swap_out_d = swap_out_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          m_big_d  = a_big ? m_a_number : m_b_number;
          e_big_d  = a_big ? e_a_number : e_b_number;
          small_d  = {(a_big ? m_b_number : m_a_number), 2'b00};
          sticky_d = 1'b0;
          op_d     = eff_op;
          swap_d   = ~a_big;
          // Beyond ShW shifts the small operand lives only in sticky.
          if (32'(diff) >= ShW) cnt_d = SIZE_COUNTER'(ShW);
          else                  cnt_d = SIZE_COUNTER'(diff);
          state_d  = StAlign;
        end
      end
      StAlign: begin
        if (cnt_q == '0) begin
          state_d = StAdd;
        end else begin
          small_d  = small_q >> 1;
          sticky_d = sticky_q | small_q[0];
          cnt_d    = cnt_q - SIZE_COUNTER'(1);
        end
      end
      StAdd: begin
        sum_d   = op_q ? (big_ext - small_ext) : (big_ext + small_ext);
        state_d = StNorm;
      end
      StNorm: begin
        if (sum_q[SumW-1]) begin
          res_m_d = sum_q[SumW-1 -: SIZE_MANTISSA];
          grs_d   = {sum_q[3], sum_q[2], sum_q[1] | sum_q[0]};
          res_e_d = e_big_q + SIZE_EXPONENT'(1);
        end else if (!sum_q[SumW-2]) begin
          res_m_d = sum_q[SumW-3 -: SIZE_MANTISSA];
          grs_d   = {sum_q[1], sum_q[0], sum_q[0]};
          res_e_d = e_big_q - SIZE_EXPONENT'(1);
        end else begin
          res_m_d = sum_q[SumW-2 -: SIZE_MANTISSA];
          grs_d   = sum_q[2:0];
          res_e_d = e_big_q;
        end
        swap_out_d = swap_q;
        state_d    = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      m_big_q    <= '0;
      e_big_q    <= '0;
      small_q    <= '0;
      sticky_q   <= 1'b0;
      op_q       <= 1'b0;
      swap_q     <= 1'b0;
      cnt_q      <= '0;
      sum_q      <= '0;
      res_m_q    <= '0;
      grs_q      <= '0;
      res_e_q    <= '0;
      swap_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_big_q    <= m_big_d;
      e_big_q    <= e_big_d;
      small_q    <= small_d;
      sticky_q   <= sticky_d;
      op_q       <= op_d;
      swap_q     <= swap_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      res_m_q    <= res_m_d;
      grs_q      <= grs_d;
      res_e_q    <= res_e_d;
      swap_out_q <= swap_out_d;
    end
  end

  assign resulted_m_o = res_m_q;
  assign grs_o        = grs_q;
  assign resulted_e_o = res_e_q;
  assign swap_o       = swap_out_q;

endmodule

// File: tb/tb_far_path_seq.sv
// Bench for far_path_seq: arithmetic reference model checked every cycle, plus directed
// operand pairs with literal expected results and latencies.
module tb_far_path_seq;

  localparam int SM = 24;
  localparam int SE = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          eff_op;
  logic [SM-1:0] m_a_number, m_b_number;
  logic [SE-1:0] e_a_number, e_b_number;
  logic          out_valid;
  logic          out_ready;
  logic [SM-1:0] resulted_m_o;
  logic [2:0]    grs_o;
  logic [SE-1:0] resulted_e_o;
  logic          swap_o;

  int checks   = 0;
  int failures = 0;

  far_path_seq #(
    .SIZE_MANTISSA(SM),
    .SIZE_EXPONENT(SE),
    .SIZE_COUNTER (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .eff_op      (eff_op),
    .m_a_number  (m_a_number),
    .m_b_number  (m_b_number),
    .e_a_number  (e_a_number),
    .e_b_number  (e_b_number),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .resulted_m_o(resulted_m_o),
    .grs_o       (grs_o),
    .resulted_e_o(resulted_e_o),
    .swap_o      (swap_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SM-1:0] m;
    logic [2:0]    grs;
    logic [SE-1:0] e;
    logic          swap;
    logic          dc;
  } res_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact arithmetic on the shifted-out value rather than bit-serial alignment.
  function automatic res_t model(input logic [SM-1:0] ma, input logic [SE-1:0] ea,
                                 input logic [SM-1:0] mb, input logic [SE-1:0] eb,
                                 input logic op);
    res_t r;
    logic [63:0] mbig, msml, d, cnt, full, aligned, big_v, sml_v, sum, mask;
    logic [SE-1:0] ebig, esml;
    logic stk;
    if (ea >= eb) begin
      mbig = 64'(ma); msml = 64'(mb); ebig = ea; esml = eb; r.swap = 1'b0;
    end else begin
      mbig = 64'(mb); msml = 64'(ma); ebig = eb; esml = ea; r.swap = 1'b1;
    end
    d       = 64'(ebig - esml);
    cnt     = (d > 64'(SM + 2)) ? 64'(SM + 2) : d;
    full    = msml << 2;
    aligned = full >> cnt;
    mask    = (64'd1 << cnt) - 64'd1;
    stk     = (full & mask) != 64'd0;
    big_v   = mbig << 3;
    sml_v   = (aligned << 1) | 64'(stk);
    sum     = op ? (big_v - sml_v) : (big_v + sml_v);
    r.dc    = op && (d < 64'd2);
    if (sum >= (64'd1 << (SM + 3))) begin
      r.m   = SM'(sum >> 4);
      r.grs = {sum[3], sum[2], sum[1] | sum[0]};
      r.e   = ebig + 8'd1;
    end else if (sum < (64'd1 << (SM + 2))) begin
      r.m   = SM'(sum >> 2);
      r.grs = {sum[1], sum[0], sum[0]};
      r.e   = ebig - 8'd1;
    end else begin
      r.m   = SM'(sum >> 3);
      r.grs = sum[2:0];
      r.e   = ebig;
    end
    return r;
  endfunction

  // Transaction-level timing model: busy for d_eff+3 edges, then valid until accepted.
  logic busy_m, valid_m;
  int   wait_m;
  res_t pend_m, exp_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m  <= 1'b0;
      valid_m <= 1'b0;
      wait_m  <= 0;
      pend_m  <= '0;
      exp_m   <= '0;
    end else if (valid_m) begin
      if (out_ready) valid_m <= 1'b0;
    end else if (busy_m) begin
      if (wait_m == 1) begin
        busy_m  <= 1'b0;
        valid_m <= 1'b1;
        exp_m   <= pend_m;
      end
      wait_m <= wait_m - 1;
    end else if (in_valid) begin
      int d;
      if (e_a_number >= e_b_number) d = int'(e_a_number - e_b_number);
      else                          d = int'(e_b_number - e_a_number);
      if (d > SM + 2) d = SM + 2;
      busy_m <= 1'b1;
      wait_m <= d + 3;
      pend_m <= model(m_a_number, e_a_number, m_b_number, e_b_number, eff_op);
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(!busy_m && !valid_m));
    chk("out_valid", 64'(out_valid), 64'(valid_m));
    if (!exp_m.dc) begin
      chk("mant", 64'(resulted_m_o), 64'(exp_m.m));
      chk("grs", 64'(grs_o), 64'(exp_m.grs));
      chk("exp", 64'(resulted_e_o), 64'(exp_m.e));
      chk("swap", 64'(swap_o), 64'(exp_m.swap));
    end
  end

  task automatic run_op(input logic [SM-1:0] ma, input logic [SE-1:0] ea,
                        input logic [SM-1:0] mb, input logic [SE-1:0] eb, input logic op,
                        input int hold, input int exp_lat, input logic lit,
                        input logic [SM-1:0] xm, input logic [2:0] xgrs,
                        input logic [SE-1:0] xe, input logic xswap);
    int lat;
    @(posedge clk); #1;
    m_a_number = ma; e_a_number = ea; m_b_number = mb; e_b_number = eb; eff_op = op;
    in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs while busy; in_valid stays high through the handshake.
    m_a_number = SM'($urandom); m_b_number = SM'($urandom);
    e_a_number = SE'($urandom); e_b_number = SE'($urandom); eff_op = ~op;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    if (lit) begin
      chk("lit_mant", 64'(resulted_m_o), 64'(xm));
      chk("lit_grs", 64'(grs_o), 64'(xgrs));
      chk("lit_exp", 64'(resulted_e_o), 64'(xe));
      chk("lit_swap", 64'(swap_o), 64'(xswap));
    end
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("post_ready", 64'(in_ready), 64'd1);
    chk("post_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; eff_op = 1'b0;
    m_a_number = '0; m_b_number = '0; e_a_number = '0; e_b_number = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_mant", 64'(resulted_m_o), 64'd0);
    chk("rst_grs", 64'(grs_o), 64'd0);
    chk("rst_exp", 64'(resulted_e_o), 64'd0);
    chk("rst_swap", 64'(swap_o), 64'd0);
    rst_n = 1'b1;

    run_op(24'h800000, 8'd130, 24'h800000, 8'd128, 1'b0, 0, 5, 1'b1, 24'hA00000, 3'b000, 8'd130, 1'b0);
    run_op(24'h800000, 8'd130, 24'hC00000, 8'd128, 1'b1, 0, 5, 1'b1, 24'hA00000, 3'b000, 8'd129, 1'b0);
    run_op(24'hFFFFFF, 8'd130, 24'hFFFFFF, 8'd128, 1'b0, 0, 5, 1'b1, 24'h9FFFFF, 3'b011, 8'd131, 1'b0);
    run_op(24'h800000, 8'd210, 24'hFFFFFF, 8'd10,  1'b1, 0, 29, 1'b1, 24'hFFFFFF, 3'b111, 8'd209, 1'b0);
    run_op(24'h800000, 8'd130, 24'h800000, 8'd140, 1'b0, 10, 13, 1'b1, 24'h802000, 3'b000, 8'd140, 1'b1);
    run_op(24'h800000, 8'd100, 24'h800000, 8'd100, 1'b0, 0, 3, 1'b1, 24'h800000, 3'b000, 8'd101, 1'b0);
    run_op(24'hC00001, 8'd51,  24'h800001, 8'd50,  1'b0, 0, 4, 1'b1, 24'h800000, 3'b110, 8'd52, 1'b0);
    run_op(24'hFFFFFF, 8'd255, 24'hFFFFFF, 8'd253, 1'b0, 2, 5, 1'b1, 24'h9FFFFF, 3'b011, 8'd0, 1'b0);
    // d<2 subtract: result is don't-care, only the handshake is checked.
    run_op(24'h900000, 8'd70,  24'hF00000, 8'd71,  1'b1, 1, 4, 1'b0, '0, '0, '0, 1'b0);
    run_op(24'hABCDEF, 8'd60,  24'h987654, 8'd35,  1'b1, 0, 28, 1'b0, '0, '0, '0, 1'b0);
    run_op(24'h876543, 8'd20,  24'hFEDCBA, 8'd27,  1'b1, 3, 10, 1'b0, '0, '0, '0, 1'b1);

    // Abandon a d=20 operation in ALIGN.
    @(posedge clk); #1;
    m_a_number = 24'h900000; e_a_number = 8'd150;
    m_b_number = 24'hA00000; e_b_number = 8'd130; eff_op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_mant", 64'(resulted_m_o), 64'd0);
    chk("midrst_exp", 64'(resulted_e_o), 64'd0);
    chk("midrst_swap", 64'(swap_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(24'h800000, 8'd130, 24'h800000, 8'd128, 1'b0, 0, 5, 1'b1, 24'hA00000, 3'b000, 8'd130, 1'b0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
